// File: rtl/posit_pkg.sv
// Shared definitions for the posit decoder datapath.
// - N_DEF / TAG_W_DEF : default posit width and sideband tag width
// - calc_w / calc_kw  : data path width (N-1) and regime-count width (clog2(N))
// - stage_payload_t   : per-stage payload (data, lost, tag) at the default sizes
package posit_pkg;

  localparam int unsigned N_DEF     = 64;
  localparam int unsigned TAG_W_DEF = 4;

  function automatic int unsigned calc_w(input int unsigned n);
    return n - 1;
  endfunction

  function automatic int unsigned calc_kw(input int unsigned n);
    return $clog2(n);
  endfunction

  typedef struct packed {
    logic [N_DEF-2:0]     data;
    logic                 lost;
    logic [TAG_W_DEF-1:0] tag;
  } stage_payload_t;

endpackage

// File: rtl/posit_shift_stage.sv
// One register stage worth of the normalising barrel shifter (combinational part).
// Applies up to LVL_CNT conditional left-shift levels, starting at level LVL_LO.
// Level j shifts by 2^j when s[j] is set; bits pushed above bit W-1 are ORed into lost.
// Ports:
//   data_in  : word entering this stage
//   lost_in  : lost flag accumulated by earlier stages
//   s        : full shift amount (only this stage's level bits are used)
//   data_out : shifted word
//   lost_out : updated lost flag
module posit_shift_stage
  import posit_pkg::*;
#(
  parameter int unsigned W       = calc_w(N_DEF),
  parameter int unsigned KW      = calc_kw(N_DEF),
  parameter int unsigned LVL_LO  = 0,
  parameter int unsigned LVL_CNT = 2
) (
  input  logic [W-1:0] data_in,
  input  logic         lost_in,
  input  logic [KW:0]  s,
  output logic [W-1:0] data_out,
  output logic         lost_out
);

  // Only the bits selecting this stage's levels matter here.
  logic unused_s;
  assign unused_s = ^s;

  logic [W-1:0] d;
  logic [W-1:0] hi;
  logic         l;

  always_comb begin
    d  = data_in;
    l  = lost_in;
    hi = '0;
    for (int unsigned j = 0; j < LVL_CNT; j++) begin
      if (s[LVL_LO + j]) begin
        // Mask of the top 2^j bits about to leave the word; all ones once 2^j >= W.
        hi = ~({W{1'b1}} >> (32'd1 << (LVL_LO + j)));
        l  = l | (|(d & hi));
        d  = d << (32'd1 << (LVL_LO + j));
      end
    end
  end

  assign data_out = d;
  assign lost_out = l;

endmodule

// File: rtl/posit_norm_shifter_pipe.sv
// Pipelined normalising left shifter: out_data = in_data << (in_k+1), truncated to W bits.
// The KW+1 barrel levels are grouped LPS per register stage; latency ceil((KW+1)/LPS).
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   in_valid/in_ready               : input handshake
//   in_data, in_k, in_tag           : post-sign word, regime run count, sideband tag
//   out_valid/out_ready             : output handshake
//   out_data, out_lost, out_zero    : shifted word, any 1 shifted out, result is zero
//   out_tag                         : tag of the same transaction
module posit_norm_shifter_pipe
  import posit_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned KW    = calc_kw(N),
  parameter int unsigned LPS   = 2,
  parameter int unsigned TAG_W = TAG_W_DEF,
  localparam int unsigned W    = calc_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [KW-1:0]    in_k,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_lost,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LEVELS = KW + 1;
  localparam int unsigned L      = (LEVELS + LPS - 1) / LPS;
  localparam int unsigned SW     = KW + 1;

  // Per-stage state flattened into buses; slot i belongs to stage i.
  logic [L-1:0]       v;
  logic [L-1:0]       adv;
  logic [L*W-1:0]     d_bus;
  logic [L-1:0]       l_bus;
  logic [L*TAG_W-1:0] t_bus;
  logic [L*SW-1:0]    s_bus;   // shift amount feeding stage i

  // Held one bit wider than in_k so in_k = 2^KW-1 does not wrap to 0.
  logic [SW-1:0] s_first;
  assign s_first = SW'(in_k) + SW'(1);

  // A stage advances if it is empty or everything downstream advances.
  always_comb begin
    logic a;
    a   = out_ready;
    adv = '0;
    for (int i = int'(L) - 1; i >= 0; i--) begin
      a      = ~v[i] | a;
      adv[i] = a;
    end
  end

  assign in_ready = adv[0];

  for (genvar i = 0; i < L; i++) begin : g_stage
    localparam int unsigned LO  = i * LPS;
    localparam int unsigned CNT = ((LEVELS - LO) < LPS) ? (LEVELS - LO) : LPS;

    logic [W-1:0]     d_in;
    logic             l_in;
    logic [TAG_W-1:0] t_in;
    logic             v_in;
    logic [SW-1:0]    s_cur;
    logic [W-1:0]     d_nxt;
    logic             l_nxt;
    logic [W-1:0]     d_q;
    logic             l_q;
    logic [TAG_W-1:0] t_q;
    logic             v_q;

    if (i == 0) begin : g_head
      assign d_in  = in_data;
      assign l_in  = 1'b0;
      assign t_in  = in_tag;
      assign v_in  = in_valid;
      assign s_cur = s_first;
    end else begin : g_tail
      logic [SW-1:0] s_q;
      assign d_in  = d_bus[(i-1)*W +: W];
      assign l_in  = l_bus[i-1];
      assign t_in  = t_bus[(i-1)*TAG_W +: TAG_W];
      assign v_in  = v[i-1];
      // Travels alongside the payload of the previous stage's register.
      always_ff @(posedge clk) begin
        if (adv[i-1]) begin
          s_q <= s_bus[(i-1)*SW +: SW];
        end
      end
      assign s_cur = s_q;
    end

    posit_shift_stage #(
      .W       (W),
      .KW      (KW),
      .LVL_LO  (LO),
      .LVL_CNT (CNT)
    ) u_shift (
      .data_in  (d_in),
      .lost_in  (l_in),
      .s        (s_cur),
      .data_out (d_nxt),
      .lost_out (l_nxt)
    );

    if (i == L - 1) begin : g_last
      // Output register is reset so the visible outputs are clean after reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d_q <= '0;
          l_q <= 1'b0;
          t_q <= '0;
        end else if (adv[i]) begin
          d_q <= d_nxt;
          l_q <= l_nxt;
          t_q <= t_in;
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (adv[i]) begin
          d_q <= d_nxt;
          l_q <= l_nxt;
          t_q <= t_in;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (adv[i]) begin
        v_q <= v_in;
      end
    end

    assign v[i]                      = v_q;
    assign d_bus[i*W +: W]           = d_q;
    assign l_bus[i]                  = l_q;
    assign t_bus[i*TAG_W +: TAG_W]   = t_q;
    assign s_bus[i*SW +: SW]         = s_cur;
  end

  assign out_valid = v[L-1];
  assign out_data  = d_bus[(L-1)*W +: W];
  assign out_lost  = l_bus[L-1];
  assign out_tag   = t_bus[(L-1)*TAG_W +: TAG_W];
  // Qualified by valid so the flag reads 0 while the pipe is empty or in reset.
  assign out_zero  = v[L-1] & ~(|out_data);

endmodule

// File: tb/tb_posit_norm_shifter_pipe.sv
// Self-checking bench for posit_norm_shifter_pipe (N=64, LPS=2, latency 4).
module tb_posit_norm_shifter_pipe;

  localparam int unsigned W     = 63;
  localparam int unsigned KW    = 6;
  localparam int unsigned TAG_W = 4;
  localparam int          LAT   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [KW-1:0]    in_k;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_lost;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  posit_norm_shifter_pipe #(
    .N     (64),
    .KW    (KW),
    .LPS   (2),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_k      (in_k),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lost  (out_lost),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [W-1:0]     data;
    logic             lost;
    logic [TAG_W-1:0] tag;
    int               cyc;
    bit               chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  bit   lat_on   = 1'b0;
  bit   stalled  = 1'b0;
  logic [W-1:0]     hold_d;
  logic             hold_l;
  logic [TAG_W-1:0] hold_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: shift into a wide word so nothing is lost, then split.
  function automatic exp_t model(input logic [W-1:0] d, input logic [KW-1:0] k,
                                 input logic [TAG_W-1:0] t);
    logic [127:0] full;
    int           s;
    exp_t         e;
    s         = int'(k) + 1;
    full      = {65'b0, d} << s;
    e.data    = full[W-1:0];
    e.lost    = |full[127:W];
    e.tag     = t;
    e.cyc     = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: compare outputs against the scoreboard, record accepted inputs.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(out_tag), 64'hFFFF);
        end else begin
          mon_e = sb.pop_front();
          check("data", 64'(out_data), 64'(mon_e.data));
          check("lost", 64'(out_lost), 64'(mon_e.lost));
          check("zero", 64'(out_zero), 64'(mon_e.data == '0));
          check("tag", 64'(out_tag), 64'(mon_e.tag));
          if (mon_e.chk_lat) check("latency", 64'(cyc - mon_e.cyc), 64'(LAT));
        end
      end
      if (out_valid && !out_ready) begin
        if (stalled) begin
          check("stall_data", 64'(out_data), 64'(hold_d));
          check("stall_lost", 64'(out_lost), 64'(hold_l));
          check("stall_tag", 64'(out_tag), 64'(hold_t));
        end
        stalled = 1'b1;
        hold_d  = out_data;
        hold_l  = out_lost;
        hold_t  = out_tag;
      end else begin
        stalled = 1'b0;
      end
      if (in_valid && in_ready) begin
        mon_e         = model(in_data, in_k, in_tag);
        mon_e.cyc     = cyc;
        mon_e.chk_lat = lat_on;
        sb.push_back(mon_e);
        n_acc++;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [KW-1:0] k,
                      input logic [TAG_W-1:0] t);
    bit acc;
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_k     = k;
    in_tag   = t;
    acc      = 1'b0;
    waited   = 0;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_k      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_lost", 64'(out_lost), 64'd0);
    check("rst_zero", 64'(out_zero), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed cases, back to back
    lat_on = 1'b1;
    send(63'h1, 6'd0, 4'd1);
    send(63'h4000_0000_0000_0000, 6'd0, 4'd2);
    send(63'h4000_0000_0000_0000, 6'd5, 4'd3);
    send(63'h7FFF_FFFF_FFFF_FFFF, 6'd61, 4'd4);
    send(63'h7FFF_FFFF_FFFF_FFFF, 6'd62, 4'd5);
    send(63'h7FFF_FFFF_FFFF_FFFF, 6'd63, 4'd6);
    in_valid = 1'b0;
    drain(50);

    // Random stream at full throughput
    for (int i = 0; i < 20; i++) begin
      send(W'({$urandom(), $urandom()}), KW'($urandom_range(0, 63)), TAG_W'(i));
    end
    in_valid = 1'b0;
    drain(50);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: 6 pushes against a 10-cycle stall
    lat_on    = 1'b0;
    n_acc     = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(W'({$urandom(), $urandom()}), KW'($urandom_range(0, 63)), TAG_W'(8 + i));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        check("bp_accepts", 64'(n_acc), 64'd4);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    drain(50);
    check("bp_total", 64'(n_acc), 64'd6);

    // Reset with transactions in flight
    out_ready = 1'b0;
    send(63'h11, 6'd2, 4'd1);
    send(63'h22, 6'd3, 4'd2);
    send(63'h33, 6'd4, 4'd3);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    lat_on    = 1'b1;
    send(63'h3, 6'd1, 4'd7);
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("post_rst_data", 64'(out_data), 64'hC);
    end
    drain(20);
    repeat (5) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
